// File: rtl/dot_acc_pkg.sv
// Shared types and default widths for the dot-product accumulator stage.
package dot_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 24;
    localparam int CNT_W      = 8;

endpackage

// File: rtl/dot_acc_add.sv
// Accumulator adder with carry out; clamps to all-ones when DOT_ACC_SATURATE_EN is defined.
module dot_acc_add
    import dot_acc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] addend,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] wide_sum;

    always_comb begin
        wide_sum = {1'b0, acc} + (ACC_W+1)'(addend);
        carry    = wide_sum[ACC_W];
`ifdef DOT_ACC_SATURATE_EN
        // Once clamped, max + x still carries, so the sum stays pinned for the vector.
        sum = carry ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
`else
        sum = wide_sum[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/dot_acc_stage.sv
// Dot-product accumulator: sums LEN (or fewer, on in_last) products and holds the result.
// Optional clamping on overflow via DOT_ACC_SATURATE_EN.
module dot_acc_stage
    import dot_acc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;
    logic               close_term;

    dot_acc_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc    (acc_q),
        .addend (in_data),
        .sum    (add_sum),
        .carry  (add_carry)
    );

    // Widened compare so cnt_q+1 cannot wrap before matching LEN.
    assign close_term = in_last || (({1'b0, cnt_q} + 9'd1) == 9'(LEN));

    assign in_ready  = !reset && (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign out_data  = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, ACCUM: begin
                    if (in_valid) begin
                        acc_d   = add_sum;
                        cnt_d   = cnt_q + 8'd1;
                        ovf_d   = ovf_q | add_carry;
                        state_d = close_term ? HOLD : ACCUM;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
